// File: rtl/riscv_core_dcache_ctrl.sv
// Direct-mapped, write-back data-cache controller: tag/valid/dirty bookkeeping,
// hit/miss handling, AMO read-modify-write, victim write-back, refill and full flush.
module riscv_core_dcache_ctrl #(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 52,
  parameter int ADDR_WIDTH  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic                  i_amo,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_flush,
  output logic                  o_done,
  output logic                  o_stall,
  output logic                  o_flush_done,
  output logic                  o_rd_en,
  output logic                  o_wr_en,
  output logic                  o_amo_wr,
  output logic                  o_block_replace,
  output logic [ADDR_WIDTH-1:0] o_dp_addr,
  output logic                  o_axi_rd_req,
  output logic [ADDR_WIDTH-1:0] o_axi_rd_addr,
  input  logic                  i_axi_rd_valid,
  output logic                  o_axi_wr_req,
  output logic [ADDR_WIDTH-1:0] o_axi_wr_addr,
  input  logic                  i_axi_wr_done
);

  localparam int OFFS_W = 5;
  localparam int SETS   = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AMO_WR,
    S_WRITEBACK,
    S_REFILL,
    S_FLUSH_SCAN,
    S_FLUSH_WB,
    S_FLUSH_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SETS-1:0]        valid_q, valid_d;
  logic [SETS-1:0]        dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0]   tag_q [SETS];
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic                   tag_we;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag_in;
  logic                   hit;
  logic [ADDR_WIDTH-1:0]  victim_addr;
  logic [ADDR_WIDTH-1:0]  flush_addr;

  assign idx         = i_addr[OFFS_W +: INDEX_WIDTH];
  assign tag_in      = i_addr[OFFS_W+INDEX_WIDTH +: TAG_WIDTH];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag_in);
  assign victim_addr = {tag_q[idx], idx, {OFFS_W{1'b0}}};
  assign flush_addr  = {tag_q[cnt_q], cnt_q, {OFFS_W{1'b0}}};

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    cnt_d           = cnt_q;
    tag_we          = 1'b0;
    o_done          = 1'b0;
    o_flush_done    = 1'b0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    o_amo_wr        = 1'b0;
    o_block_replace = 1'b0;
    o_dp_addr       = i_addr;
    o_axi_rd_req    = 1'b0;
    o_axi_rd_addr   = '0;
    o_axi_wr_req    = 1'b0;
    o_axi_wr_addr   = '0;

    case (state_q)
      S_IDLE: begin
        // A flush request wins; any concurrent access simply stalls until it is done.
        if (i_flush) begin
          state_d = S_FLUSH_SCAN;
          cnt_d   = '0;
        end else if (i_req) begin
          if (hit) begin
            if (i_amo) begin
              o_rd_en = 1'b1;
              state_d = S_AMO_WR;
            end else if (i_we) begin
              o_wr_en      = 1'b1;
              o_done       = 1'b1;
              dirty_d[idx] = 1'b1;
            end else begin
              o_rd_en = 1'b1;
              o_done  = 1'b1;
            end
          end else begin
            state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
          end
        end
      end
      S_AMO_WR: begin
        o_wr_en      = 1'b1;
        o_amo_wr     = 1'b1;
        o_done       = 1'b1;
        dirty_d[idx] = 1'b1;
        state_d      = S_IDLE;
      end
      S_WRITEBACK: begin
        o_axi_wr_req  = 1'b1;
        o_axi_wr_addr = victim_addr;
        if (i_axi_wr_done) begin
          dirty_d[idx] = 1'b0;
          state_d      = S_REFILL;
        end
      end
      S_REFILL: begin
        o_axi_rd_req  = 1'b1;
        o_axi_rd_addr = {i_addr[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
        if (i_axi_rd_valid) begin
          o_wr_en         = 1'b1;
          o_block_replace = 1'b1;
          tag_we          = 1'b1;
          valid_d[idx]    = 1'b1;
          dirty_d[idx]    = 1'b0;
          state_d         = S_IDLE;
        end
      end
      S_FLUSH_SCAN: begin
        o_dp_addr = flush_addr;
        if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
          state_d = S_FLUSH_WB;
        end else if (cnt_q == '1) begin
          state_d = S_FLUSH_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FLUSH_WB: begin
        o_dp_addr     = flush_addr;
        o_axi_wr_req  = 1'b1;
        o_axi_wr_addr = flush_addr;
        // The last set exits straight to DONE so the counter never wraps into a rescan.
        if (i_axi_wr_done) begin
          dirty_d[cnt_q] = 1'b0;
          if (cnt_q == '1) begin
            state_d = S_FLUSH_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_FLUSH_SCAN;
          end
        end
      end
      S_FLUSH_DONE: begin
        o_dp_addr    = flush_addr;
        o_flush_done = 1'b1;
        cnt_d        = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    o_stall = i_req && !o_done;

    if (i_rst) begin
      o_done          = 1'b0;
      o_stall         = 1'b0;
      o_flush_done    = 1'b0;
      o_rd_en         = 1'b0;
      o_wr_en         = 1'b0;
      o_amo_wr        = 1'b0;
      o_block_replace = 1'b0;
      o_dp_addr       = '0;
      o_axi_rd_req    = 1'b0;
      o_axi_rd_addr   = '0;
      o_axi_wr_req    = 1'b0;
      o_axi_wr_addr   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag storage carries no reset; valid bits qualify every entry.
  always_ff @(posedge i_clk) begin
    if (tag_we && !i_rst) begin
      tag_q[idx] <= tag_in;
    end
  end

endmodule

// File: tb/tb_riscv_core_dcache_ctrl.sv
// Bench for riscv_core_dcache_ctrl: directed vector table, flush/reset sequences,
// and random accesses checked against a transaction-level cache model.
module tb_riscv_core_dcache_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we, amo, flush, rd_valid, wr_done;
  logic [63:0] addr;
  logic        o_done, o_stall, o_flush_done, o_rd_en, o_wr_en, o_amo_wr, o_block_replace;
  logic [63:0] o_dp_addr, o_axi_rd_addr, o_axi_wr_addr;
  logic        o_axi_rd_req, o_axi_wr_req;

  riscv_core_dcache_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_amo(amo), .i_addr(addr),
    .i_flush(flush), .o_done(o_done), .o_stall(o_stall), .o_flush_done(o_flush_done),
    .o_rd_en(o_rd_en), .o_wr_en(o_wr_en), .o_amo_wr(o_amo_wr),
    .o_block_replace(o_block_replace), .o_dp_addr(o_dp_addr),
    .o_axi_rd_req(o_axi_rd_req), .o_axi_rd_addr(o_axi_rd_addr), .i_axi_rd_valid(rd_valid),
    .o_axi_wr_req(o_axi_wr_req), .o_axi_wr_addr(o_axi_wr_addr), .i_axi_wr_done(wr_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-set valid/dirty/tag
  bit          m_valid [128];
  bit          m_dirty [128];
  logic [51:0] m_tag   [128];

  task automatic model_clear();
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  typedef struct {
    logic        rq, w, m, rv, wd;
    logic [63:0] a;
    logic        done, stall, rd, wr, aw, rp, rr, wrq;
    logic [63:0] ra, wa;
  } vec_t;

  function automatic vec_t mk(input logic rq, w, m, rv, wd, input logic [63:0] a,
                              input logic done, stall, rd, wr, aw, rp, rr, wrq,
                              input logic [63:0] ra, wa);
    vec_t v;
    v.rq = rq; v.w = w; v.m = m; v.rv = rv; v.wd = wd; v.a = a;
    v.done = done; v.stall = stall; v.rd = rd; v.wr = wr; v.aw = aw; v.rp = rp;
    v.rr = rr; v.wrq = wrq; v.ra = ra; v.wa = wa;
    return v;
  endfunction

  // One access held until done; AXI answered after rlat/wlat extra cycles.
  task automatic do_access(input logic [63:0] a, input logic w, input logic m,
                           input int rlat, input int wlat);
    logic [6:0]  ix;
    logic [51:0] t;
    logic [63:0] vaddr, raddr;
    bit hit, wb, done_seen, waddr_ok, raddr_ok, repl_ok, strobe_ok, stall_ok, prev_rd;
    int cyc, wcnt, rcnt, ncyc;
    ix    = a[11:5];
    t     = a[63:12];
    hit   = m_valid[ix] && (m_tag[ix] == t);
    wb    = !hit && m_valid[ix] && m_dirty[ix];
    vaddr = {m_tag[ix], ix, 5'b0};
    raddr = {a[63:5], 5'b0};
    ncyc  = (m ? 2 : 1) + (hit ? 0 : 1 + (rlat + 1) + (wb ? wlat + 1 : 0));
    req = 1'b1; we = w; amo = m; addr = a;
    waddr_ok = 1; raddr_ok = 1; repl_ok = 1; strobe_ok = 0; stall_ok = 1; prev_rd = 0;
    done_seen = 0; cyc = 0; wcnt = 0; rcnt = 0;
    while (!done_seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (o_stall !== !o_done) stall_ok = 0;
      if (o_axi_wr_req) begin
        wcnt++;
        if (o_axi_wr_addr !== vaddr) waddr_ok = 0;
        if (wcnt == wlat + 1) wr_done = 1'b1;
      end
      if (o_axi_rd_req) begin
        rcnt++;
        if (o_axi_rd_addr !== raddr) raddr_ok = 0;
        if (rcnt == rlat + 1) begin
          rd_valid = 1'b1;
          #1;
          if (!(o_wr_en && o_block_replace && !o_done)) repl_ok = 0;
        end
      end
      if (o_done) begin
        done_seen = 1;
        if (m)      strobe_ok = o_wr_en && o_amo_wr && !o_rd_en && prev_rd;
        else if (w) strobe_ok = o_wr_en && !o_rd_en && !o_amo_wr;
        else        strobe_ok = o_rd_en && !o_wr_en && !o_amo_wr;
      end
      prev_rd = o_rd_en && !o_wr_en;
      @(posedge clk);
      #1;
      wr_done = 1'b0; rd_valid = 1'b0;
    end
    req = 1'b0; we = 1'b0; amo = 1'b0;
    chk($sformatf("done@%0h", a), done_seen, 1);
    chk($sformatf("latency@%0h", a), cyc, ncyc);
    chk($sformatf("wb_cycles@%0h", a), wcnt, wb ? wlat + 1 : 0);
    chk($sformatf("wb_addr@%0h", a), waddr_ok, 1);
    chk($sformatf("refill_cycles@%0h", a), rcnt, hit ? 0 : rlat + 1);
    chk($sformatf("refill_addr@%0h", a), raddr_ok, 1);
    chk($sformatf("replace@%0h", a), repl_ok, 1);
    chk($sformatf("strobes@%0h", a), strobe_ok, 1);
    chk($sformatf("stall@%0h", a), stall_ok, 1);
    if (!hit) begin
      m_valid[ix] = 1'b1;
      m_tag[ix]   = t;
      m_dirty[ix] = 1'b0;
    end
    if (w || m) m_dirty[ix] = 1'b1;
  endtask

  vec_t        vecs[$];
  logic [63:0] wbq[$];

  initial begin
    localparam logic [63:0] A1 = 64'h1000, A2 = 64'h1008, A3 = 64'h3000, A4 = 64'h3010;
    vecs.push_back(mk(1,0,0,0,0,A1, 0,1,0,0,0,0,0,0, 0,0));   // miss, invalid set
    vecs.push_back(mk(1,0,0,0,0,A1, 0,1,0,0,0,0,1,0, A1,0));
    vecs.push_back(mk(1,0,0,0,0,A1, 0,1,0,0,0,0,1,0, A1,0));
    vecs.push_back(mk(1,0,0,0,0,A1, 0,1,0,0,0,0,1,0, A1,0));
    vecs.push_back(mk(1,0,0,1,0,A1, 0,1,0,1,0,1,1,0, A1,0));   // refill data
    vecs.push_back(mk(1,0,0,0,0,A1, 1,0,1,0,0,0,0,0, 0,0));   // re-evaluated hit
    vecs.push_back(mk(1,1,0,0,0,A2, 1,0,0,1,0,0,0,0, 0,0));   // store hit
    vecs.push_back(mk(1,0,0,0,0,A3, 0,1,0,0,0,0,0,0, 0,0));   // conflict miss, dirty
    vecs.push_back(mk(1,0,0,0,0,A3, 0,1,0,0,0,0,0,1, 0,A1));
    vecs.push_back(mk(1,0,0,0,1,A3, 0,1,0,0,0,0,0,1, 0,A1));
    vecs.push_back(mk(1,0,0,0,0,A3, 0,1,0,0,0,0,1,0, A3,0));
    vecs.push_back(mk(1,0,0,1,0,A3, 0,1,0,1,0,1,1,0, A3,0));
    vecs.push_back(mk(1,0,0,0,0,A3, 1,0,1,0,0,0,0,0, 0,0));
    vecs.push_back(mk(1,1,1,0,0,A4, 0,1,1,0,0,0,0,0, 0,0));   // AMO read phase
    vecs.push_back(mk(1,1,1,0,0,A4, 1,0,0,1,1,0,0,0, 0,0));   // AMO write phase
    vecs.push_back(mk(0,0,0,1,1,A1, 0,0,0,0,0,0,0,0, 0,0));   // stray responses ignored
    vecs.push_back(mk(1,0,0,0,0,A3, 1,0,1,0,0,0,0,0, 0,0));

    rst = 1'b1; req = 1'b0; we = 1'b0; amo = 1'b0; flush = 1'b0;
    rd_valid = 1'b0; wr_done = 1'b0; addr = '0;
    model_clear();
    @(posedge clk); #1;
    req = 1'b1; addr = A1;
    @(negedge clk);
    chk("rst_done", o_done, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_axi_rd_req", o_axi_rd_req, 0);
    chk("rst_axi_wr_req", o_axi_wr_req, 0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].rq; we = vecs[i].w; amo = vecs[i].m; addr = vecs[i].a;
      rd_valid = vecs[i].rv; wr_done = vecs[i].wd;
      @(negedge clk);
      chk($sformatf("v%0d_done", i), o_done, vecs[i].done);
      chk($sformatf("v%0d_stall", i), o_stall, vecs[i].stall);
      chk($sformatf("v%0d_rd_en", i), o_rd_en, vecs[i].rd);
      chk($sformatf("v%0d_wr_en", i), o_wr_en, vecs[i].wr);
      chk($sformatf("v%0d_amo_wr", i), o_amo_wr, vecs[i].aw);
      chk($sformatf("v%0d_replace", i), o_block_replace, vecs[i].rp);
      chk($sformatf("v%0d_axi_rd_req", i), o_axi_rd_req, vecs[i].rr);
      chk($sformatf("v%0d_axi_wr_req", i), o_axi_wr_req, vecs[i].wrq);
      chk($sformatf("v%0d_flush_done", i), o_flush_done, 0);
      chk($sformatf("v%0d_dp_addr", i), o_dp_addr, vecs[i].a);
      if (vecs[i].rr) chk($sformatf("v%0d_axi_rd_addr", i), o_axi_rd_addr, vecs[i].ra);
      if (vecs[i].wrq) chk($sformatf("v%0d_axi_wr_addr", i), o_axi_wr_addr, vecs[i].wa);
      @(posedge clk); #1;
    end
    req = 1'b0; we = 1'b0; amo = 1'b0; rd_valid = 1'b0; wr_done = 1'b0;
    m_valid[0] = 1'b1; m_tag[0] = 52'h3; m_dirty[0] = 1'b1;

    // Dirty set 5 as well, then flush with a load pending
    do_access(64'h70A0, 1'b1, 1'b0, 1, 0);
    begin
      int  fcyc, wc;
      bit  fd, dp_ok, quiet_ok, prev_wr;
      req = 1'b1; we = 1'b0; amo = 1'b0; addr = A1; flush = 1'b1;
      @(negedge clk);
      chk("flush_prio_done", o_done, 0);
      chk("flush_prio_stall", o_stall, 1);
      chk("flush_prio_rd_en", o_rd_en, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      fcyc = 1; wc = 0; fd = 0; dp_ok = 1; quiet_ok = 1; prev_wr = 0;
      while (!fd && fcyc < 1000) begin
        @(negedge clk);
        fcyc++;
        if (o_axi_wr_req) begin
          if (!prev_wr) wbq.push_back(o_axi_wr_addr);
          if (o_dp_addr !== o_axi_wr_addr) dp_ok = 0;
          wc++;
          if (wc == 2) begin
            wr_done = 1'b1;
            wc = 0;
          end
        end
        prev_wr = o_axi_wr_req;
        if (o_axi_rd_req || o_done || o_rd_en || o_wr_en) quiet_ok = 0;
        if (o_flush_done) fd = 1;
        @(posedge clk); #1;
        wr_done = 1'b0;
      end
      chk("flush_done_seen", fd, 1);
      chk("flush_cycles", fcyc, 134);
      chk("flush_wb_count", wbq.size(), 2);
      if (wbq.size() == 2) begin
        chk("flush_wb0_addr", wbq[0], 64'h3000);
        chk("flush_wb1_addr", wbq[1], 64'h70A0);
      end
      chk("flush_dp_addr", dp_ok, 1);
      chk("flush_no_access", quiet_ok, 1);
      for (int i = 0; i < 128; i++) m_dirty[i] = 1'b0;
    end
    do_access(A1, 1'b0, 1'b0, 1, 0);

    // Reset during refill aborts it
    req = 1'b1; we = 1'b0; amo = 1'b0; addr = 64'h5000;
    @(negedge clk);
    chk("rstr_miss_rd_req", o_axi_rd_req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstr_refill_rd_req", o_axi_rd_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstr_idle_rd_req", o_axi_rd_req, 0);
    chk("rstr_idle_done", o_done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstr_remiss_rd_req", o_axi_rd_req, 1);
    chk("rstr_remiss_addr", o_axi_rd_addr, 64'h5000);
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    do_access(A1, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [63:0] r, a;
      logic [51:0] t;
      int tsel;
      r = {$urandom, $urandom};
      tsel = $urandom_range(0, 4);
      t = (tsel < 4) ? 52'(tsel) : r[51:0];
      a = {t, 7'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      do_access(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_core_dcache_ctrl.md
RISCV_CORE_DCACHE_CTRL -- requirements
Module: riscv_core_dcache_ctrl

Interface
REQ-001 SHALL use parameter INDEX_WIDTH, default 7, meaning set-index width; 128 direct-mapped sets.
REQ-002 SHALL use parameter TAG_WIDTH, default 52, meaning tag width, taken from address bits [63:12].
REQ-003 SHALL use parameter ADDR_WIDTH, default 64, meaning address width; block offset is bits [4:0] (32-byte block).
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 i_clk  in  1  clock; all state updates on its rising edge.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_req / i_we / i_amo  in  1 each  core access valid, store, atomic RMW; i_req held until o_done.
REQ-008 i_addr  in  64  core byte address.
REQ-009 i_flush  in  1  request write-back of all dirty lines.
REQ-010 o_done  out  1  access completes this cycle; o_stall  out  1  equals i_req && !o_done.
REQ-011 o_flush_done  out  1  one-cycle pulse when flush finishes.
REQ-012 o_rd_en, o_wr_en, o_amo_wr, o_block_replace  out  1 each  data-array strobes.
REQ-013 o_dp_addr  out  64  address driven to the data array; equals i_addr except in flush states.
REQ-014 o_axi_rd_req  out  1, o_axi_rd_addr  out  64 (block aligned), i_axi_rd_valid  in  1  refill block present on the AXI data bus.
REQ-015 o_axi_wr_req  out  1, o_axi_wr_addr  out  64 (block aligned), i_axi_wr_done  in  1  victim write accepted.

Function
REQ-016 SHALL hold valid[128], dirty[128] and tag[128][52] arrays internally; hit = valid[idx] && tag[idx]==i_addr[63:12].
REQ-017 States: IDLE, AMO_WR, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
REQ-018 IDLE, i_req, hit, load: o_rd_en=1, o_done=1 in the same cycle (0-cycle latency).
REQ-019 IDLE, i_req, hit, store: o_wr_en=1, o_done=1, dirty[idx]<=1.
REQ-020 IDLE, i_req, hit, i_amo: cycle 1 o_rd_en=1, go to AMO_WR; cycle 2 o_wr_en=1, o_amo_wr=1, o_done=1, dirty<=1, go to IDLE.
REQ-021 IDLE, i_req, miss: go to WRITEBACK if valid[idx]&&dirty[idx], else to REFILL; o_done=0.
REQ-022 WRITEBACK: o_axi_wr_req=1, o_axi_wr_addr={tag[idx],idx,5'b0} held stable; on i_axi_wr_done go to REFILL, dirty[idx]<=0.
REQ-023 REFILL: o_axi_rd_req=1, o_axi_rd_addr={i_addr[63:5],5'b0}; on i_axi_rd_valid drive o_wr_en=1, o_block_replace=1, tag<=i_addr tag, valid<=1, dirty<=0, go to IDLE.
REQ-024 After refill, IDLE re-evaluates the held request as a hit; miss load latency without victim = 1 + AXI read latency + 1 cycles.
REQ-025 i_flush is sampled only in IDLE and has priority over i_req in the same cycle; the pending i_req stalls.
REQ-026 FLUSH_SCAN: counter 0..127; if valid&&dirty go to FLUSH_WB, else increment; after index 127 go to FLUSH_DONE.
REQ-027 FLUSH_WB: o_dp_addr={tag[cnt],cnt,5'b0}, o_axi_wr_req=1 as in WRITEBACK; on i_axi_wr_done clear dirty[cnt], increment the counter, return to FLUSH_SCAN.
REQ-028 FLUSH_DONE: o_flush_done=1 for one cycle, go to IDLE; valid bits are kept.
REQ-029 AXI request lines SHALL stay asserted and addresses stable until the matching response; responses in other states are ignored.
REQ-030 All strobes and o_done SHALL be 0 in every state/condition not listed above.

Reset
REQ-031 i_rst SHALL force IDLE, flush counter 0, all valid and dirty bits 0, all outputs 0; tag contents are don't-care.
REQ-032 Reset asserted mid-WRITEBACK/REFILL/flush SHALL abort the transaction; AXI requests drop in the next cycle.

Verification
REQ-033 Reset, load 0x1000 -> miss, o_axi_rd_req with addr 0x1000; i_axi_rd_valid after 3 cycles -> o_block_replace pulse, next cycle o_rd_en=1, o_done=1.
REQ-034 Store 0x1008 hit -> o_wr_en=1, o_done same cycle; then load 0x3000 (same idx 0) -> o_axi_wr_req addr 0x1000, then o_axi_rd_req addr 0x3000.
REQ-035 AMO 0x3010 hit -> cycle 1 o_rd_en only, cycle 2 o_wr_en=1, o_amo_wr=1, o_done=1.
REQ-036 Dirty lines at idx 0 and 5, i_flush together with i_req -> two write-backs, addresses 0x3000 and {tag,5,0}, o_flush_done after scan reaches 127, then the request proceeds.
REQ-037 i_rst during REFILL -> IDLE next cycle, o_axi_rd_req=0, load to the same address misses again.
